counter_sequencer: RTL and testbench

- Controller that sequences the 3-bit counter datapath through a programmed number of count passes.
- Each pass clears the counter, enables it until the count reaches a programmed target, then either starts the next pass or signals completion.
- Sits between a host start/stop handshake and the counter's enable and clear inputs. It observes the counter value and drives no arithmetic of its own apart from the pass counter.

---
 rtl/counter_sequencer.sv | 143 ++++++++++++++
 tb/tb_counter_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: steps an external WIDTH-bit counter through a programmed
// number of count passes. Each pass clears the counter for one cycle and then
// enables it until it reaches the captured target. When the last pass ends the
// block pulses done. A stop request ends the run early and pulses aborted.
//
// Optional build macro SEQ_PROGRESS_REAL_EN adds a simulation-only real output
// 'progress' that reports the completed fraction of the run.
module counter_sequencer #(
  parameter int WIDTH = 3,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] target,
  input  logic [PW-1:0]    passes,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             aborted,
`ifdef SEQ_PROGRESS_REAL_EN
  output real              progress,
`endif
  output logic [PW-1:0]    pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    passes_q, passes_d;
  logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [PW-1:0]    pass_cnt_inc;
  logic             at_target;

  assign pass_cnt_inc = pass_cnt_q + PW'(1);
  assign at_target    = (count == target_q);

  // State and run-configuration registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  // Next-state logic: start accepted only in IDLE, stop aborts CLEAR and RUN.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          target_d   = target;
          passes_d   = (passes == '0) ? PW'(1) : passes;
          pass_cnt_d = '0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = stop ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_ABORT;
        end else if (at_target) begin
          pass_cnt_d = pass_cnt_inc;
          state_d    = (pass_cnt_inc == passes_q) ? S_DONE : S_CLEAR;
        end
      end
      // done has already been signalled, so a late stop changes nothing.
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; cnt_en follows count combinationally while in RUN.
  always_comb begin
    cnt_en  = (state_q == S_RUN) && !at_target;
    cnt_clr = (state_q == S_CLEAR);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    aborted = (state_q == S_ABORT);
  end

  assign pass_cnt = pass_cnt_q;

`ifdef SEQ_PROGRESS_REAL_EN
  logic complete_q;

  // Remembers that the last run finished normally so IDLE can report 1.0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      complete_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      complete_q <= 1'b1;
    end else if (state_d == S_CLEAR && state_q == S_IDLE) begin
      complete_q <= 1'b0;
    end else if (state_q == S_ABORT) begin
      complete_q <= 1'b0;
    end
  end

  // Fraction of the total count steps covered so far in this run.
  always_comb begin
    real span;
    span     = real'(passes_q) * (real'(target_q) + 1.0);
    progress = 0.0;
    unique case (state_q)
      S_RUN:   progress = (real'(pass_cnt_q) * (real'(target_q) + 1.0)
                           + real'(count)) / span;
      S_CLEAR: progress = (real'(pass_cnt_q) * (real'(target_q) + 1.0)) / span;
      S_DONE:  progress = 1.0;
      S_IDLE:  progress = complete_q ? 1.0 : 0.0;
      default: progress = 0.0;
    endcase
  end
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer with a behavioural 3-bit counter
// attached. Stimulus pushes expected done/aborted events into a scoreboard;
// a monitor pops and compares them whenever the DUT pulses.
module tb_counter_sequencer;

  localparam int WIDTH = 3;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] target = '0;
  logic [PW-1:0]    passes = '0;
  logic [WIDTH-1:0] count;
  logic             cnt_en, cnt_clr, busy, done, aborted;
  logic [PW-1:0]    pass_cnt;
`ifdef SEQ_PROGRESS_REAL_EN
  real              progress;
`endif

  counter_sequencer #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .target   (target),
    .passes   (passes),
    .count    (count),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
`ifdef SEQ_PROGRESS_REAL_EN
    .progress (progress),
`endif
    .pass_cnt (pass_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural counter: clear has priority over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       count <= '0;
    else if (cnt_clr) count <= '0;
    else if (cnt_en)  count <= count + 3'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [3:0]  pc;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_real(input string name, input real act, input real exp);
    checks++;
    if (act > exp + 1.0e-9 || act < exp - 1.0e-9) begin
      errors++;
      $display("FAIL %s: got %f expected %f (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done/aborted pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (reset && (done || aborted)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, done, aborted}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_done",     {31'd0, done},    {31'd0, e.is_done});
        check("pulse_aborted",  {31'd0, aborted}, {31'd0, !e.is_done});
        check("pulse_edge",     cyc,              e.edge_no);
        check("pulse_pass_cnt", {28'd0, pass_cnt}, {28'd0, e.pc});
      end
    end
  end

  // Issues a start; returns at the negedge after the start edge (edge 0).
  task automatic do_start(input logic [2:0] t, input logic [3:0] p,
                          output int e0);
    @(negedge clk);
    target = t;
    passes = p;
    start  = 1'b1;
    e0     = cyc + 1;
    @(negedge clk);
    start  = 1'b0;
    target = ~t;
    passes = ~p;
  endtask

  task automatic wait_count(input logic [2:0] v);
    for (int i = 0; i < 32; i++) begin
      if (count == v) break;
      @(negedge clk);
    end
    check("wait_count", {29'd0, count}, {29'd0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;

    // Reset state.
    #2;
    check("rst_cnt_en",   {31'd0, cnt_en},  32'd0);
    check("rst_cnt_clr",  {31'd0, cnt_clr}, 32'd0);
    check("rst_busy",     {31'd0, busy},    32'd0);
    check("rst_pass_cnt", {28'd0, pass_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset asserted mid-RUN.
    do_start(3'd5, 4'd1, e0);
    wait_count(3'd3);
    #1 reset = 1'b0;
    #1;
    check("midrst_cnt_en",   {31'd0, cnt_en},  32'd0);
    check("midrst_cnt_clr",  {31'd0, cnt_clr}, 32'd0);
    check("midrst_busy",     {31'd0, busy},    32'd0);
    check("midrst_done",     {31'd0, done},    32'd0);
    check("midrst_aborted",  {31'd0, aborted}, 32'd0);
    check("midrst_pass_cnt", {28'd0, pass_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);

    // target=3, passes=2: clears in cycles 1 and 6, done 10 edges after start.
    do_start(3'd3, 4'd2, e0);
    sb.push_back('{is_done: 1'b1, pc: 4'd2, edge_no: e0 + 10});
    for (int j = 0; j < 10; j++) begin
      check($sformatf("t2_clr_%0d", j), {31'd0, cnt_clr},
            (j == 0 || j == 5) ? 32'd1 : 32'd0);
      if (j != 0 && j != 5) begin
        check($sformatf("t2_count_%0d", j), {29'd0, count}, (j - 1) % 5);
        check($sformatf("t2_en_%0d", j), {31'd0, cnt_en},
              ((j - 1) % 5 == 3) ? 32'd0 : 32'd1);
      end
`ifdef SEQ_PROGRESS_REAL_EN
      if (j == 6) check_real("t2_progress_half", progress, 0.5);
`endif
      @(negedge clk);
    end
    check("t2_done_now", {31'd0, done}, 32'd1);
`ifdef SEQ_PROGRESS_REAL_EN
    check_real("t2_progress_done", progress, 1.0);
`endif
    @(negedge clk);
    @(negedge clk);
    check("t2_idle_busy",     {31'd0, busy},    32'd0);
    check("t2_hold_pass_cnt", {28'd0, pass_cnt}, 32'd2);

    // target=0, passes=0 (treated as 1): done 2 edges after start.
    do_start(3'd0, 4'd0, e0);
    sb.push_back('{is_done: 1'b1, pc: 4'd1, edge_no: e0 + 2});
    check("t3_clear", {31'd0, cnt_clr}, 32'd1);
    @(negedge clk);
    check("t3_run_en",  {31'd0, cnt_en},  32'd0);
    check("t3_run_clr", {31'd0, cnt_clr}, 32'd0);
    check("t3_run_busy", {31'd0, busy},   32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t3_idle_busy", {31'd0, busy}, 32'd0);

    // target=7, passes=1, stop when count=4: abort on the next edge.
    do_start(3'd7, 4'd1, e0);
    sb.push_back('{is_done: 1'b0, pc: 4'd0, edge_no: e0 + 6});
    wait_count(3'd4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_abort_en",       {31'd0, cnt_en},  32'd0);
    check("t4_abort_pass_cnt", {28'd0, pass_cnt}, 32'd0);
    @(negedge clk);
    check("t4_idle_busy", {31'd0, busy},   32'd0);
    check("t4_idle_en",   {31'd0, cnt_en}, 32'd0);

    // start and stop together in IDLE: stop wins.
    @(negedge clk);
    start  = 1'b1;
    stop   = 1'b1;
    target = 3'd2;
    passes = 4'd1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("t5_both_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t5_both_busy2", {31'd0, busy}, 32'd0);

    // start while busy is ignored; the run length stays 1*(2+2).
    do_start(3'd2, 4'd1, e0);
    sb.push_back('{is_done: 1'b1, pc: 4'd1, edge_no: e0 + 4});
    start  = 1'b1;
    target = 3'd7;
    passes = 4'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("t5_final_busy",     {31'd0, busy},    32'd0);
    check("t5_final_pass_cnt", {28'd0, pass_cnt}, 32'd1);

    // Every expected event must have been seen.
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
